// File: rtl/add_mul_i8.sv
// ============================================================================
// Module      : add_mul_i8
// Description : Combinational integer multiply-add, y = (a * b + c) mod 2^WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_mul_i8 #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] y
);

    localparam int c_PW = 2 * WIDTH;

    logic [c_PW-1:0] w_prod;
    logic [c_PW-1:0] w_c_ext;
    logic [c_PW-1:0] w_sum;
    logic            w_unused;

    // Low WIDTH bits are sign-agnostic, so an unsigned product serves signed operands too.
    assign w_prod  = c_PW'(a) * c_PW'(b);
    assign w_c_ext = {{WIDTH{c[WIDTH-1]}}, c};
    assign w_sum   = w_prod + w_c_ext;
    assign y       = w_sum[WIDTH-1:0];

    // Clock and reset exist only for a uniform interface; they never reach y.
    assign w_unused = &{1'b0, clock, reset, w_sum[c_PW-1:WIDTH]};

endmodule

`default_nettype wire

// File: tb/tb_add_mul_i8.sv
// ============================================================================
// Module      : tb_add_mul_i8
// Description : Scoreboard bench for add_mul_i8, directed vectors plus random.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add_mul_i8;

    typedef struct {
        logic [7:0] exp;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        int         id;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] a     = '0;
    logic [7:0] b     = '0;
    logic [7:0] c     = '0;
    logic [7:0] y;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   done   = 1'b0;

    add_mul_i8 #(.WIDTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .a     (a),
        .b     (b),
        .c     (c),
        .y     (y)
    );

    always #5 clock = ~clock;

    // Reference model: plain signed integer arithmetic, wrapped to 8 bits.
    function automatic logic [7:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                         input logic [7:0] mc);
        int p;
        p = int'($signed(ma)) * int'($signed(mb)) + int'($signed(mc));
        return p[7:0];
    endfunction

    // Drive one vector just after a clock edge; the check lands before the next edge.
    task automatic issue(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] tc,
                         input logic trst, input logic [7:0] texp, input int tid);
        exp_t e;
        @(clock);
        #1;
        a     = ta;
        b     = tb_;
        c     = tc;
        reset = trst;
        e.exp = texp;
        e.a   = ta;
        e.b   = tb_;
        e.c   = tc;
        e.id  = tid;
        q.push_back(e);
    endtask

    // Monitor: samples y each half cycle, well away from the edges.
    initial begin
        exp_t e;
        while (!done) begin
            @(clock);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (y !== e.exp) begin
                    errors++;
                    $display("FAIL vec%0d a=%h b=%h c=%h: y=%h expected=%h",
                             e.id, e.a, e.b, e.c, y, e.exp);
                end
            end
        end
    end

    initial begin
        logic [7:0] da [10] = '{8'h04, 8'h04, 8'hFD, 8'hFC, 8'h10, 8'h7F, 8'h80, 8'hFF, 8'h00, 8'h01};
        logic [7:0] db [10] = '{8'h02, 8'h02, 8'h05, 8'hFC, 8'h10, 8'h02, 8'h80, 8'hFF, 8'h5A, 8'h33};
        logic [7:0] dc [10] = '{8'h03, 8'h03, 8'h02, 8'hFF, 8'h05, 8'h03, 8'h80, 8'h00, 8'h77, 8'h00};
        logic [7:0] dy [10] = '{8'h0B, 8'h0B, 8'hF3, 8'h0F, 8'h05, 8'h01, 8'h80, 8'h01, 8'h77, 8'h33};
        logic       dr [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [7:0] ra, rb, rc;
        logic       rr;

        repeat (2) @(posedge clock);

        for (int i = 0; i < 10; i++)
            issue(da[i], db[i], dc[i], dr[i], dy[i], i);

        // Random operands with reset toggling underneath, new inputs every half cycle.
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 8'($urandom);
            case ($urandom_range(0, 7))
                0: begin ra = 8'h00; end
                1: begin rb = 8'h00; end
                2: begin rc = 8'h00; end
                3: begin ra = 8'h80; end
                default: ;
            endcase
            rr = ($urandom_range(0, 9) == 0) ? 1'bx : 1'($urandom);
            issue(ra, rb, rc, rr, model(ra, rb, rc), 100 + i);
        end

        for (int k = 0; k < 10 && q.size() > 0; k++)
            @(clock);
        #4;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending=%0d expected=0", q.size());
        end
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
